// File: rtl/avmm_pck_pkg.sv
// avmm_pck_pkg: field layout, response codes and FSM states shared by both ends of the packed AVMM link
package avmm_pck_pkg;
  localparam int TX_WR = 0;
  localparam int TX_RD = 1;
  localparam int TX_BE_LSB = 2;
  localparam int BE_W = 8;
  localparam int TX_ADDR_LSB = 10;
  localparam int RX_VALID = 0;
  localparam int RX_RESP_LSB = 1;
  localparam int RX_DATA_LSB = 3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {ST_INIT, ST_READY} state_t;
  function automatic int tx_width(int addr_w, int data_w);
    return 2 + data_w / 8 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/avmm_pck_csr_responder_if.sv
// avmm_pck_csr_responder_if: packed Tx command, packed Rx response and link status
interface avmm_pck_csr_responder_if
  import avmm_pck_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic [tx_width(ADDR_W, DATA_W)-1:0] pck_tx;
  logic                                waitrequest;
  logic [DATA_W+2:0]                   pck_rx;
  logic                                init_done;
  modport master(output pck_tx, input waitrequest, pck_rx, init_done);
  modport slave(input pck_tx, output waitrequest, pck_rx, init_done);
endinterface

// File: rtl/avmm_pck_regfile.sv
// avmm_pck_regfile: byte-enabled CSR array, one write port with init-clear override, one registered read port
module avmm_pck_regfile #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             init,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       be,
  input  logic [63:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [63:0]      rdata
);
  logic [63:0]      mem [NUM_REGS];
  logic             wen;
  logic [IDX_W-1:0] wa;
  logic [7:0]       wbe;
  logic [63:0]      wd;
  always_comb begin
    wen = init | we;
    wa  = init ? clr_idx : widx;
    wbe = init ? 8'hFF : be;
    wd  = init ? '0 : wdata;
  end
  // No reset on contents so the array maps onto RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (wen && wbe[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
    rdata <= mem[ridx];
  end
endmodule

// File: rtl/avmm_pck_csr_responder.sv
// avmm_pck_csr_responder: terminating CSR responder on the packed AVMM link,
// clears its register file after reset, then serves reads with a fixed latency of two.
module avmm_pck_csr_responder
  import avmm_pck_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 64,
  parameter int                NUM_REGS = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  avmm_pck_csr_responder_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  state_t            state, state_nx;
  logic [IDX_W-1:0]  clr_idx, idx1;
  logic [ADDR_W-1:0] addr, word;
  logic              wr, rd, acc, in_range, is_id, we;
  logic              v1, err1, id1, v2, err2, id2;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W+2:0] rx_d;
  always_comb begin
    wr       = bus.pck_tx[TX_WR];
    rd       = bus.pck_tx[TX_RD];
    addr     = bus.pck_tx[TX_ADDR_LSB +: ADDR_W];
    word     = addr >> 3;
    in_range = (word >> IDX_W) == '0;
    is_id    = word == '0;
    acc      = (wr | rd) & ~bus.waitrequest;
    // read+write together is an erroring read, so it never writes
    we       = acc & wr & ~rd & in_range & ~is_id;
    state_nx = (state == ST_INIT && clr_idx == IDX_W'(NUM_REGS - 1)) ? ST_READY : state;
    rx_d     = '0;
    rx_d[RX_VALID] = v2;
    rx_d[RX_RESP_LSB +: 2] = (v2 && err2) ? RESP_SLVERR : RESP_OKAY;
    rx_d[RX_DATA_LSB +: DATA_W] = (!v2 || err2) ? '0 : id2 ? ID_VALUE : rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_INIT;
      clr_idx         <= '0;
      bus.waitrequest <= 1'b1;
      bus.init_done   <= 1'b0;
      v1              <= 1'b0;
      err1            <= 1'b0;
      id1             <= 1'b0;
      idx1            <= '0;
      v2              <= 1'b0;
      err2            <= 1'b0;
      id2             <= 1'b0;
      bus.pck_rx      <= '0;
    end else begin
      state           <= state_nx;
      clr_idx         <= (state == ST_INIT) ? clr_idx + 1'b1 : clr_idx;
      bus.waitrequest <= state != ST_READY;
      bus.init_done   <= state == ST_READY;
      v1              <= acc & rd;
      err1            <= wr | ~in_range;
      id1             <= is_id;
      idx1            <= word[IDX_W-1:0];
      v2              <= v1;
      err2            <= err1;
      id2             <= id1;
      bus.pck_rx      <= rx_d;
    end
  end
  avmm_pck_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk    (clk),
    .init   (state == ST_INIT),
    .clr_idx(clr_idx),
    .we     (we),
    .widx   (word[IDX_W-1:0]),
    .be     (bus.pck_tx[TX_BE_LSB +: BE_W]),
    .wdata  (bus.pck_tx[TX_ADDR_LSB + ADDR_W +: DATA_W]),
    .ridx   (idx1),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_avmm_pck_csr_responder.sv
// tb_avmm_pck_csr_responder: directed and random commands checked every cycle against a behavioural CSR model
module tb_avmm_pck_csr_responder;
  localparam int NR = 32;
  localparam logic [63:0] ID = 64'hCAFE_0001;
  typedef struct {int due; logic [66:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [63:0] mm [NR];
  int e = 0;
  exp_t q[$];
  logic [66:0] seen[$];
  avmm_pck_csr_responder_if #(.ADDR_W(16), .DATA_W(64)) bus ();
  avmm_pck_csr_responder #(.ADDR_W(16), .DATA_W(64), .NUM_REGS(NR), .ID_VALUE(ID)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Model: edges since reset release decide readiness; reads resolve at acceptance, due two edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0;
      q.delete();
      for (int i = 0; i < NR; i++) mm[i] = '0;
    end else begin
      logic [89:0] t;
      int w;
      bit ok;
      t = bus.pck_tx;
      ok = e >= NR + 1;
      e++;
      w = int'(t[25:13]);
      if (ok && t[1])
        q.push_back('{e + 2, (t[0] || w >= NR) ? {64'h0, 2'b10, 1'b1}
                                               : {(w == 0) ? ID : mm[w], 2'b00, 1'b1}});
      else if (ok && t[0] && w != 0 && w < NR)
        for (int b = 0; b < 8; b++) if (t[2+b]) mm[w][b*8 +: 8] = t[26+b*8 +: 8];
    end
  end
  always @(negedge clk) begin
    logic [66:0] ex;
    exp_t h;
    ex = '0;
    if (rst_n && q.size() > 0 && q[0].due == e) begin
      h = q.pop_front();
      ex = h.v;
    end
    chk("rx", bus.pck_rx, ex);
    chk("waitrequest", 67'(bus.waitrequest), 67'(rst_n ? (e < NR + 1) : 1'b1));
    chk("init_done", 67'(bus.init_done), 67'(rst_n && e >= NR + 1));
    if (rst_n && bus.pck_rx[0]) seen.push_back(bus.pck_rx);
  end
  task automatic issue(input logic w, input logic r, input logic [15:0] a, input logic [7:0] be,
                       input logic [63:0] d);
    int n = 0;
    bus.pck_tx = {d, a, be, r, w};
    while (bus.waitrequest && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 67'(n), 67'(0));
    @(negedge clk);
    bus.pck_tx = '0;
  endtask
  task automatic read_chk(input string name, input logic [15:0] a, input logic [66:0] exp);
    issue(1'b0, 1'b1, a, 8'h00, 64'h0);
    @(negedge clk);
    chk({name, "_gap"}, bus.pck_rx, 67'h0);
    @(negedge clk);
    chk(name, bus.pck_rx, exp);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.pck_tx = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 67'(bus.waitrequest), 67'(1));
    chk("rst_rx", bus.pck_rx, 67'h0);
    chk("rst_init_done", 67'(bus.init_done), 67'(0));
    rst_n = 1'b1;
    for (n = 1; n < 100; n++) begin
      @(negedge clk);
      if (!bus.waitrequest) break;
    end
    chk("wait_edges", 67'(n), 67'(33));
    chk("init_done_rise", 67'(bus.init_done), 67'(1));
    issue(1'b1, 1'b0, 16'h0008, 8'hFF, 64'h1122334455667788);
    issue(1'b1, 1'b0, 16'h0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    read_chk("raw_merge", 16'h0008, {64'h11223344BBBBBBBB, 2'b00, 1'b1});
    read_chk("id_read", 16'h0000, {ID, 2'b00, 1'b1});
    issue(1'b1, 1'b0, 16'h0000, 8'hFF, 64'hFFFF);
    read_chk("id_ro", 16'h0000, {ID, 2'b00, 1'b1});
    read_chk("oob_read", 16'h0100, {64'h0, 2'b10, 1'b1});
    issue(1'b1, 1'b0, 16'h0100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < NR; i++) issue(1'b0, 1'b1, 16'(i * 8), 8'h00, 64'h0);
    for (int i = 1; i < 4; i++) issue(1'b1, 1'b0, 16'(i * 8), 8'hFF, 64'(i));
    repeat (3) @(negedge clk);
    seen.delete();
    issue(1'b0, 1'b1, 16'h0008, 8'h00, 64'h0);
    issue(1'b0, 1'b1, 16'h0010, 8'h00, 64'h0);
    issue(1'b0, 1'b1, 16'h0018, 8'h00, 64'h0);
    issue(1'b0, 1'b1, 16'h0008, 8'h00, 64'h0);
    repeat (3) @(negedge clk);
    chk("b2b_count", 67'(seen.size()), 67'(4));
    if (seen.size() == 4) begin
      chk("b2b_0", seen[0], {64'd1, 2'b00, 1'b1});
      chk("b2b_1", seen[1], {64'd2, 2'b00, 1'b1});
      chk("b2b_2", seen[2], {64'd3, 2'b00, 1'b1});
      chk("b2b_3", seen[3], {64'd1, 2'b00, 1'b1});
    end
    issue(1'b1, 1'b1, 16'h0018, 8'hFF, 64'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("rw_both", bus.pck_rx, {64'h0, 2'b10, 1'b1});
    read_chk("rw_both_nochange", 16'h0018, {64'd3, 2'b00, 1'b1});
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      issue(k >= 6, (k >= 2 && k <= 5) || k == 9, 16'($urandom_range(0, 16'h13F)),
            8'($urandom), {$urandom, $urandom});
    end
    repeat (4) @(negedge clk);
    issue(1'b1, 1'b0, 16'h0008, 8'hFF, 64'h55);
    seen.delete();
    issue(1'b0, 1'b1, 16'h0008, 8'h00, 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (bus.waitrequest && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_timeout", 67'(n < 100), 67'(1));
    chk("no_valid_after_reset", 67'(seen.size()), 67'(0));
    read_chk("cleared_after_reset", 16'h0008, {64'h0, 2'b00, 1'b1});
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
